// File: rtl/piano_pkg.sv
// Shared constants for the piano front end: input counts, button indices and
// default timing in 100 MHz clock cycles.
package piano_pkg;

    localparam int N_BTN = 3;
    localparam int N_KEY = 7;

    localparam int BTN_PREV  = 0;
    localparam int BTN_PAUSE = 1;
    localparam int BTN_NEXT  = 2;

    localparam int DB_CYCLES_DEF   = 2_000_000;
    localparam int HOLD_CYCLES_DEF = 50_000_000;
    localparam int REP_CYCLES_DEF  = 20_000_000;
    localparam logic [N_BTN-1:0] REPEAT_MASK_DEF = 3'b101;

    // A counter that must reach n-1 needs $clog2(n) bits, never fewer than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input bit: two-flop synchroniser, stability counter and debounced level,
// with a single-cycle pulse on each accepted 0->1 change.
module debounce_cell
    import piano_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // Next-state: count consecutive disagreeing samples, flip on the last one.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces the three board buttons and seven note keys, and adds hold-to-repeat
// pulses on the buttons selected by REPEAT_MASK.
module input_conditioner
    import piano_pkg::*;
#(
    parameter int                 DB_CYCLES   = DB_CYCLES_DEF,
    parameter int                 HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int                 REP_CYCLES  = REP_CYCLES_DEF,
    parameter logic [N_BTN-1:0]   REPEAT_MASK = REPEAT_MASK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] button_raw,
    input  logic [N_KEY-1:0] key_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_KEY-1:0] key_level,
    output logic [N_KEY-1:0] key_press
);

    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int RW = cnt_width(REP_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYCLES - 1);

    logic [N_BTN-1:0] btn_level_s;
    logic [N_BTN-1:0] btn_edge_s;
    logic [N_BTN-1:0] rep_pulse_s;

    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .raw   (key_raw[i]),
            .level (key_level[i]),
            .press (key_press[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .raw   (button_raw[i]),
            .level (btn_level_s[i]),
            .press (btn_edge_s[i])
        );

        if (REPEAT_MASK[i]) begin : g_rep
            logic [HW-1:0] hold_q, hold_d;
            logic [RW-1:0] rep_cnt_q, rep_cnt_d;
            logic          rep_on_q, rep_on_d;
            logic          rep_q, rep_d;

            // Hold count is zero in the rising cycle (level was 0 before it);
            // after the first repeat a separate period counter takes over.
            always_comb begin
                hold_d    = hold_q;
                rep_cnt_d = rep_cnt_q;
                rep_on_d  = rep_on_q;
                rep_d     = 1'b0;
                if (!btn_level_s[i]) begin
                    hold_d    = '0;
                    rep_cnt_d = '0;
                    rep_on_d  = 1'b0;
                end else if (!rep_on_q) begin
                    if (hold_q == HOLD_LAST) begin
                        rep_d     = 1'b1;
                        rep_on_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end else begin
                    if (rep_cnt_q == REP_LAST) begin
                        rep_d     = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RW'(1);
                    end
                end
            end

            // Repeat state registers with asynchronous reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_q    <= '0;
                    rep_cnt_q <= '0;
                    rep_on_q  <= 1'b0;
                    rep_q     <= 1'b0;
                end else begin
                    hold_q    <= hold_d;
                    rep_cnt_q <= rep_cnt_d;
                    rep_on_q  <= rep_on_d;
                    rep_q     <= rep_d;
                end
            end

            assign rep_pulse_s[i] = rep_q;
        end else begin : g_norep
            assign rep_pulse_s[i] = 1'b0;
        end
    end

    // Gating with the level drops a repeat that lands on the release edge.
    assign btn_level = btn_level_s;
    assign btn_press = btn_edge_s | (rep_pulse_s & btn_level_s);

endmodule
